// File: rtl/blk_mixer_pkg.sv
// Shared types and constants for the dark-mode block mixer.
package blk_mixer_pkg;

  localparam int LAT       = 3;    // fixed video latency, both builds
  localparam int ALPHA_W   = 9;    // alpha spans 0..256 inclusive
  localparam int ALPHA_MAX = 256;
  localparam int CH_W      = 8;
  localparam int NUM_CH    = 3;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Saturating alpha ramp: one step toward 256 (up) or 0 (down).
  function automatic logic [ALPHA_W-1:0] alpha_next(input logic [ALPHA_W-1:0] cur,
                                                    input logic               up,
                                                    input int                 step);
    int v;
    if (up) v = int'(cur) + step;
    else    v = int'(cur) - step;
    if (v > ALPHA_MAX) v = ALPHA_MAX;
    if (v < 0)         v = 0;
    return ALPHA_W'(v);
  endfunction

endpackage

// File: rtl/blk_mix_chan.sv
// Single-channel blend, stages S2/S3: y = (c*(256-a) + (255-c)*a) >> 8.
// Build option BLK_MIXER_FADE_EN: defined -> true weighted blend with two
// multipliers; undefined -> a is only ever 0 or 256, so a select mux is used.
module blk_mix_chan
  import blk_mixer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [CH_W-1:0]    c,
  input  logic [ALPHA_W-1:0] a,
  input  logic               de,   // data-enable of the pixel entering S3
  output logic [CH_W-1:0]    y
);

`ifdef BLK_MIXER_FADE_EN
  logic [16:0]        keep_p;
  logic [16:0]        inv_p;
  logic [ALPHA_W-1:0] keep_w;
  logic [CH_W-1:0]    inv_c;

  assign keep_w = ALPHA_W'(ALPHA_MAX) - a;  // a <= 256, never underflows
  assign inv_c  = ~c;                        // 255 - c

  // S2: both weighted products
  always_ff @(posedge clk) begin
    if (rst) begin
      keep_p <= '0;
      inv_p  <= '0;
    end else begin
      keep_p <= 17'(c) * 17'(keep_w);
      inv_p  <= 17'(inv_c) * 17'(a);
    end
  end

  // S3: sum and scale; the sum peaks at 255*256 so bits [15:8] hold the result
  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= de ? CH_W'((keep_p + inv_p) >> 8) : '0;
  end
`else
  logic [CH_W-1:0] sel;

  // S2: with a in {0,256} the blend degenerates to pass or invert
  always_ff @(posedge clk) begin
    if (rst) sel <= '0;
    else     sel <= (a != '0) ? ~c : c;
  end

  // S3: extra stage keeps latency identical to the fading build
  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= de ? sel : '0;
  end
`endif

endmodule

// File: rtl/blk_mixer.sv
// Dark-mode mixer: blends pixels of bright-flagged blocks toward their inverse
// with a per-frame global alpha. Fixed 3-cycle latency, syncs delayed to match.
// Build option BLK_MIXER_FADE_EN: defined -> alpha ramps by STEP per frame;
// undefined -> alpha jumps between 0 and 256 at each vsync rising edge.
module blk_mixer
  import blk_mixer_pkg::*;
#(
  parameter int STEP = 16
)(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                hs_i,
  input  logic                vs_i,
  input  logic                de_i,
  input  logic [23:0]         rgb_i,
  input  logic                rx_i,
  output logic                hs_o,
  output logic                vs_o,
  output logic                de_o,
  output logic [23:0]         rgb_o,
  output logic [ALPHA_W-1:0]  alpha_o
);

  if (STEP < 1 || STEP > ALPHA_MAX) begin : g_bad_step
    $error("blk_mixer: STEP must be within 1..256");
  end

  logic                          vs_r;
  logic                          vs_rise;
  logic [ALPHA_W-1:0]            alpha;
  sync_t                         sync_in;
  sync_t [LAT-1:0]               sync_pipe;  // [0]=S1, [1]=S2, [2]=output
  logic [NUM_CH-1:0][CH_W-1:0]   rgb1;
  logic [ALPHA_W-1:0]            a1;
  logic [NUM_CH-1:0][CH_W-1:0]   mix;

  assign vs_rise = vs_i & ~vs_r;
  assign sync_in = '{hs: hs_i, vs: vs_i, de: de_i};

  // Vsync edge detector. Tracks vs_i during reset so a vsync that is already
  // high (or rises) while in reset is not counted as a new frame on release.
  always_ff @(posedge clk_i) begin
    vs_r <= vs_i;
  end

  // Global alpha, updated once per frame on the vsync rising edge
  always_ff @(posedge clk_i) begin
    if (rst_i)
      alpha <= '0;
    else if (vs_rise)
`ifdef BLK_MIXER_FADE_EN
      alpha <= alpha_next(alpha, en_i, STEP);
`else
      alpha <= en_i ? ALPHA_W'(ALPHA_MAX) : '0;
`endif
  end

  // Sync delay line alongside the data stages
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[LAT-2:0], sync_in};
  end

  // S1: capture pixel and its effective weight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb1 <= '0;
      a1   <= '0;
    end else begin
      rgb1 <= rgb_i;
      a1   <= (rx_i & de_i) ? alpha : '0;
    end
  end

  // S2/S3 per channel; output gated by the de of the pixel entering S3
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    blk_mix_chan u_chan (
      .clk (clk_i),
      .rst (rst_i),
      .c   (rgb1[i]),
      .a   (a1),
      .de  (sync_pipe[1].de),
      .y   (mix[i])
    );
  end

  assign rgb_o   = mix;
  assign hs_o    = sync_pipe[LAT-1].hs;
  assign vs_o    = sync_pipe[LAT-1].vs;
  assign de_o    = sync_pipe[LAT-1].de;
  assign alpha_o = alpha;

endmodule

// File: tb/tb_blk_mixer.sv
// Directed bench for blk_mixer. Inputs are driven and outputs sampled on the
// falling clock edge. Fade tests run only when BLK_MIXER_FADE_EN is defined.
module tb_blk_mixer;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, hs_i, vs_i, de_i, rx_i;
  logic [23:0] rgb_i;
  logic        hs_o, vs_o, de_o;
  logic [23:0] rgb_o;
  logic [8:0]  alpha_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  blk_mixer #(.STEP(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .hs_i(hs_i), .vs_i(vs_i),
    .de_i(de_i), .rgb_i(rgb_i), .rx_i(rx_i), .hs_o(hs_o), .vs_o(vs_o),
    .de_o(de_o), .rgb_o(rgb_o), .alpha_o(alpha_o)
  );

`ifdef BLK_MIXER_FADE_EN
  logic        hs100, vs100, de100;
  logic [23:0] rgb100;
  logic [8:0]  alpha100;

  blk_mixer #(.STEP(100)) u_dut100 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .hs_i(hs_i), .vs_i(vs_i),
    .de_i(de_i), .rgb_i(rgb_i), .rx_i(rx_i), .hs_o(hs100), .vs_o(vs100),
    .de_o(de100), .rgb_o(rgb100), .alpha_o(alpha100)
  );
`endif

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle();
    de_i = 0; rx_i = 0; hs_i = 0; rgb_i = '0;
  endtask

  task automatic vs_pulse();
    tick(); vs_i = 1;
    tick(); vs_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; en_i = 0; hs_i = 1; vs_i = 0; de_i = 1; rx_i = 1; rgb_i = 24'hABCDEF;
    repeat (5) tick();
    checks++; if ({hs_o, vs_o, de_o} !== 3'b000) begin errors++; $display("FAIL reset_sync got %b want 000", {hs_o, vs_o, de_o}); end
    checks++; if (rgb_o !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb_o); end
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL reset_alpha got %0d want 0", alpha_o); end
    rst_i = 0; hs_i = 1; de_i = 1; rx_i = 1; rgb_i = 24'h123456;
    tick(); idle();
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_lat1 de got %b want 0", de_o); end
    tick();
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_lat2 de got %b want 0", de_o); end
    tick();
    checks++; if ({hs_o, de_o} !== 2'b11) begin errors++; $display("FAIL reset_first hs/de got %b want 11", {hs_o, de_o}); end
    checks++; if (rgb_o !== 24'h123456) begin errors++; $display("FAIL reset_first rgb got %h want 123456", rgb_o); end
  endtask

  task automatic test_passthrough();
    en_i = 0;
    tick(); hs_i = 1; vs_i = 0; de_i = 1; rx_i = 1; rgb_i = 24'h123456;
    tick(); hs_i = 0; vs_i = 1; de_i = 1; rx_i = 1; rgb_i = 24'hA5C300;
    tick(); idle();
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL pass_early de got %b want 0", de_o); end
    tick(); vs_i = 0;
    checks++; if ({hs_o, vs_o, de_o} !== 3'b101) begin errors++; $display("FAIL pass_a sync got %b want 101", {hs_o, vs_o, de_o}); end
    checks++; if (rgb_o !== 24'h123456) begin errors++; $display("FAIL pass_a rgb got %h want 123456", rgb_o); end
    tick();
    checks++; if ({hs_o, vs_o, de_o} !== 3'b011) begin errors++; $display("FAIL pass_b sync got %b want 011", {hs_o, vs_o, de_o}); end
    checks++; if (rgb_o !== 24'hA5C300) begin errors++; $display("FAIL pass_b rgb got %h want a5c300", rgb_o); end
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL pass_alpha got %0d want 0", alpha_o); end
    tick();
    checks++; if ({de_o, rgb_o} !== 25'h0) begin errors++; $display("FAIL pass_idle got de=%b rgb=%h want 0", de_o, rgb_o); end
  endtask

`ifndef BLK_MIXER_FADE_EN
  task automatic test_jump();
    tick(); en_i = 1;
    tick(); tick();
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL jump_wait_vs got %0d want 0", alpha_o); end
    vs_i = 1;
    tick();
    checks++; if (alpha_o !== 9'd256) begin errors++; $display("FAIL jump_alpha got %0d want 256", alpha_o); end
    vs_i = 0; de_i = 1; rx_i = 1; rgb_i = 24'h123456;
    tick(); rx_i = 0; rgb_i = 24'h123456;
    tick(); de_i = 0; rx_i = 1; rgb_i = 24'hFFFFFF;
    tick(); idle();
    checks++; if (rgb_o !== 24'hEDCBA9) begin errors++; $display("FAIL jump_invert got %h want edcba9", rgb_o); end
    tick();
    checks++; if (rgb_o !== 24'h123456) begin errors++; $display("FAIL jump_rx0 got %h want 123456", rgb_o); end
    tick();
    checks++; if ({de_o, rgb_o} !== 25'h0) begin errors++; $display("FAIL jump_de0 got de=%b rgb=%h want 0", de_o, rgb_o); end
  endtask

  task automatic test_events();
    tick(); en_i = 0;
    tick(); en_i = 1;
    tick();
    checks++; if (alpha_o !== 9'd256) begin errors++; $display("FAIL ev_en_pulse got %0d want 256", alpha_o); end
    en_i = 0; vs_i = 1;
    tick();
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL ev_same_cycle got %0d want 0", alpha_o); end
    en_i = 1;
    tick(); tick();
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL ev_vs_held got %0d want 0", alpha_o); end
    vs_i = 0;
    tick(); vs_i = 1;
    tick(); vs_i = 0;
    checks++; if (alpha_o !== 9'd256) begin errors++; $display("FAIL ev_next_edge got %0d want 256", alpha_o); end
  endtask
`else
  task automatic test_ramp();
    int up100 [4] = '{100, 200, 256, 256};
    int dn100 [4] = '{156, 56, 0, 0};
    en_i = 1;
    for (int k = 0; k < 4; k++) begin
      vs_pulse();
      checks++; if (alpha100 !== 9'(up100[k])) begin errors++; $display("FAIL ramp100_up[%0d] got %0d want %0d", k, alpha100, up100[k]); end
    end
    repeat (4) vs_pulse();
    checks++; if (alpha_o !== 9'd128) begin errors++; $display("FAIL ramp_mid got %0d want 128", alpha_o); end
    tick(); de_i = 1; rx_i = 1; rgb_i = 24'h00FF80;
    tick(); idle();
    tick(); tick();
    checks++; if (rgb_o !== 24'h7F7F7F) begin errors++; $display("FAIL ramp_mid_pix got %h want 7f7f7f", rgb_o); end
    repeat (8) vs_pulse();
    checks++; if (alpha_o !== 9'd256) begin errors++; $display("FAIL ramp_full got %0d want 256", alpha_o); end
    tick(); de_i = 1; rx_i = 1; rgb_i = 24'h123456;
    tick(); rx_i = 0;
    tick(); idle();
    tick();
    checks++; if (rgb_o !== 24'hEDCBA9) begin errors++; $display("FAIL ramp_invert got %h want edcba9", rgb_o); end
    tick();
    checks++; if (rgb_o !== 24'h123456) begin errors++; $display("FAIL ramp_rx0 got %h want 123456", rgb_o); end
    en_i = 0;
    for (int k = 0; k < 4; k++) begin
      vs_pulse();
      checks++; if (alpha100 !== 9'(dn100[k])) begin errors++; $display("FAIL ramp100_dn[%0d] got %0d want %0d", k, alpha100, dn100[k]); end
    end
    tick(); en_i = 1;
    tick(); tick(); en_i = 0;
    tick();
    checks++; if (alpha100 !== 9'd0) begin errors++; $display("FAIL ramp100_en_pulse got %0d want 0", alpha100); end
  endtask
`endif

  task automatic test_mid_reset();
    en_i = 1;
    vs_pulse();
    tick(); de_i = 1; rx_i = 1; hs_i = 1; rgb_i = 24'h55AA33;
    tick(); rst_i = 1;
    tick(); rst_i = 0; idle();
    checks++; if ({hs_o, de_o, rgb_o} !== 26'h0) begin errors++; $display("FAIL midrst_flush got hs=%b de=%b rgb=%h want 0", hs_o, de_o, rgb_o); end
    checks++; if (alpha_o !== 9'd0) begin errors++; $display("FAIL midrst_alpha got %0d want 0", alpha_o); end
    tick(); tick(); tick();
    checks++; if ({de_o, rgb_o} !== 25'h0) begin errors++; $display("FAIL midrst_after got de=%b rgb=%h want 0", de_o, rgb_o); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
`ifndef BLK_MIXER_FADE_EN
    test_jump();
    test_events();
`else
    test_ramp();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
